data_mem_lsu: RTL and testbench

- Next-generation RV32 data memory with byte addressing, byte/half/word loads and stores, and load sign/zero extension.
- Models a slow memory through a configurable number of wait states and a request/ready handshake with busy indication.
- Sits between the core's load/store path and the data array; the core stalls while BUSY=1.
- Flags misaligned or illegal accesses instead of performing them.

---
 rtl/data_mem_lsu.sv | 162 ++++++++++++++++
 tb/tb_data_mem_lsu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// RV32 data memory behind a request/ready handshake with programmable wait states.
// It handles byte, half and word loads and stores, and rejects illegal or misaligned accesses without touching the array.
module data_mem_lsu #(
  parameter int Data_Memory_Width = 32,
  parameter int Data_Memory_Depth = 256,
  parameter int Addr_Width        = 32,
  parameter int Wait_States       = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ,
  input  logic                         WE,
  input  logic [2:0]                   FUNCT3,
  input  logic [Addr_Width-1:0]        A_Data,
  input  logic [Data_Memory_Width-1:0] WD,
  output logic [Data_Memory_Width-1:0] RD,
  output logic                         READY,
  output logic                         BUSY,
  output logic                         MISALIGN
);

  localparam int Idx_Width = $clog2(Data_Memory_Depth);
  localparam logic [3:0] Wait_Load = (Wait_States == 0) ? 4'd0 : 4'(Wait_States - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                         state_reg;
  logic [3:0]                     wait_cnt_reg;
  logic                           we_reg;
  logic [2:0]                     funct3_reg;
  logic [Addr_Width-1:0]          addr_reg;
  logic [Data_Memory_Width-1:0]   wd_reg;
  logic [Data_Memory_Width-1:0]   mem [Data_Memory_Depth];

  logic                           cur_we;
  logic [2:0]                     cur_f3;
  logic [Addr_Width-1:0]          cur_addr;
  logic [Data_Memory_Width-1:0]   cur_wd;
  logic [Addr_Width-3:0]          word_addr;
  logic [Idx_Width-1:0]           idx;
  logic [1:0]                     lane;
  logic [31:0]                    word;
  logic [31:0]                    shifted;
  logic [7:0]                     sel_byte;
  logic [15:0]                    sel_half;
  logic [31:0]                    load_val;
  logic [31:0]                    store_src;
  logic [3:0]                     byte_en;
  logic [31:0]                    store_word;
  logic                           illegal;
  logic                           misaligned;
  logic                           req_err;

  // In IDLE the access may happen on the accept edge itself, so decode the live inputs there.
  assign cur_we   = (state_reg == IDLE) ? WE     : we_reg;
  assign cur_f3   = (state_reg == IDLE) ? FUNCT3 : funct3_reg;
  assign cur_addr = (state_reg == IDLE) ? A_Data : addr_reg;
  assign cur_wd   = (state_reg == IDLE) ? WD     : wd_reg;

  assign word_addr = cur_addr[Addr_Width-1:2];
  assign idx       = Idx_Width'(word_addr % Data_Memory_Depth);
  assign lane      = cur_addr[1:0];
  assign word      = mem[idx];
  assign shifted   = word >> {lane, 3'b000};
  assign sel_byte  = shifted[7:0];
  assign sel_half  = lane[1] ? word[31:16] : word[15:0];

  assign illegal    = cur_we ? !(cur_f3 inside {3'b000, 3'b001, 3'b010})
                             : !(cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((cur_f3[1:0] == 2'b01) && lane[0]) ||
                      ((cur_f3[1:0] == 2'b10) && (lane != 2'b00));
  assign req_err    = illegal || misaligned;

  always_comb begin
    load_val = word;
    case (cur_f3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = word;
    endcase
  end

  always_comb begin
    store_src = cur_wd;
    byte_en   = 4'b1111;
    case (cur_f3[1:0])
      2'b00: begin
        store_src = {4{cur_wd[7:0]}};
        byte_en   = 4'b0001 << lane;
      end
      2'b01: begin
        store_src = {2{cur_wd[15:0]}};
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_src = cur_wd;
        byte_en   = 4'b1111;
      end
    endcase
    store_word = word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) store_word[8*b +: 8] = store_src[8*b +: 8];
    end
  end

  assign BUSY = (state_reg != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      we_reg       <= 1'b0;
      funct3_reg   <= 3'd0;
      addr_reg     <= '0;
      wd_reg       <= '0;
      RD           <= '0;
      READY        <= 1'b0;
      MISALIGN     <= 1'b0;
      for (int i = 0; i < Data_Memory_Depth; i++) mem[i] <= '0;
    end else begin
      READY    <= 1'b0;
      MISALIGN <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (REQ) begin
            we_reg     <= WE;
            funct3_reg <= FUNCT3;
            addr_reg   <= A_Data;
            wd_reg     <= WD;
            if (req_err) begin
              state_reg <= RESP;
              READY     <= 1'b1;
              MISALIGN  <= 1'b1;
            end else if (Wait_States == 0) begin
              if (cur_we) mem[idx] <= store_word;
              else        RD       <= load_val;
              state_reg <= RESP;
              READY     <= 1'b1;
            end else begin
              wait_cnt_reg <= Wait_Load;
              state_reg    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            if (cur_we) mem[idx] <= store_word;
            else        RD       <= load_val;
            state_reg <= RESP;
            READY     <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: instance 0 has two wait states and instance 1 has zero wait states.
// Each transaction's expected result is queued when the request is issued and is checked when READY arrives.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        ready [2];
  logic        busy  [2];
  logic        mis   [2];

  data_mem_lsu #(.Wait_States(2)) u_ws2 (
    .CLK(clk), .RST(rst), .REQ(req[0]), .WE(we[0]), .FUNCT3(f3[0]), .A_Data(addr[0]),
    .WD(wd[0]), .RD(rd[0]), .READY(ready[0]), .BUSY(busy[0]), .MISALIGN(mis[0])
  );

  data_mem_lsu #(.Wait_States(0)) u_ws0 (
    .CLK(clk), .RST(rst), .REQ(req[1]), .WE(we[1]), .FUNCT3(f3[1]), .A_Data(addr[1]),
    .WD(wd[1]), .RD(rd[1]), .READY(ready[1]), .BUSY(busy[1]), .MISALIGN(mis[1])
  );

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t        sb_q [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rd [2];

  // Issue one request and check READY latency, RD, MISALIGN and the return to IDLE.
  task automatic access(input int i, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_load, input logic exp_err,
                        input bit hold, input string nm);
    exp_t e;
    exp_t got;
    int   n;
    e.mis = exp_err;
    e.lat = exp_err ? 0 : ((i == 0) ? 2 : 0);
    if (!w && !exp_err) last_rd[i] = exp_load;
    e.rd = last_rd[i];
    sb_q.push_back(e);

    @(negedge clk);
    req[i] = 1'b1; we[i] = w; f3[i] = f; addr[i] = a; wd[i] = d;
    @(posedge clk); #1;
    if (!hold) req[i] = 1'b0;
    total++;
    if (busy[i] !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_accept: got %b want 1", nm, busy[i]);
    end
    n = 0;
    while (ready[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    got = sb_q.pop_front();
    total++;
    if (ready[i] !== 1'b1 || n != got.lat) begin
      bad++;
      $display("FAIL %s latency: got ready=%b after %0d edges, want %0d", nm, ready[i], n, got.lat);
    end
    total++;
    if (rd[i] !== got.rd) begin
      bad++;
      $display("FAIL %s rd: got %h want %h", nm, rd[i], got.rd);
    end
    total++;
    if (mis[i] !== got.mis) begin
      bad++;
      $display("FAIL %s misalign: got %b want %b", nm, mis[i], got.mis);
    end
    // With hold set, REQ is still high across the RESP edge and must be ignored.
    @(posedge clk); #1;
    total++;
    if (ready[i] !== 1'b0 || mis[i] !== 1'b0 || busy[i] !== 1'b0) begin
      bad++;
      $display("FAIL %s after_resp: got ready=%b mis=%b busy=%b want 0 0 0", nm, ready[i], mis[i], busy[i]);
    end
    req[i] = 1'b0;
    $display("txn %s: inst=%0d we=%b f3=%b addr=%h wd=%h rd=%h mis=%b lat=%0d",
             nm, i, w, f, a, d, rd[i], mis[i], n);
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'd0; addr[i] = 32'd0; wd[i] = 32'd0;
      last_rd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rd[i] !== 32'd0 || ready[i] !== 1'b0 || busy[i] !== 1'b0 || mis[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state%0d: got rd=%h ready=%b busy=%b mis=%b want all 0",
                 i, rd[i], ready[i], busy[i], mis[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;

    // Abort an SW while it is still waiting.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; f3[0] = 3'b010; addr[0] = 32'h10; wd[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: got busy=%b ready=%b want 0 0", busy[0], ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ready[0] === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_no_ready: got %0d pulses want 0", pulses);
    end
    $display("txn reset_abort: busy=%b ready_pulses=%0d", busy[0], pulses);
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h00000000, 1'b0, 1'b0, "lw_after_reset");
  endtask

  task automatic test_word();
    access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "sw_10");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "lw_10");
  endtask

  task automatic test_byte_lanes();
    access(0, 1'b1, 3'b000, 32'h12, 32'h000000A5, 32'h0, 1'b0, 1'b0, "sb_12");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEA5BEEF, 1'b0, 1'b0, "lw_10_merged");
    access(0, 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0, "lb_12");
    access(0, 1'b0, 3'b100, 32'h12, 32'h0, 32'h000000A5, 1'b0, 1'b0, "lbu_12");
  endtask

  task automatic test_half();
    access(0, 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0, 1'b0, "sh_22");
    access(0, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, "lh_22");
    access(0, 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 1'b0, "lhu_22");
    access(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, 1'b0, "lw_20");
  endtask

  task automatic test_errors();
    access(0, 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1, "lw_13_mis");
    access(0, 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0, 1'b1, 1'b1, "sh_21_mis");
    access(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, "f3_011_illegal");
    access(0, 1'b1, 3'b100, 32'h10, 32'h11111111, 32'h0, 1'b1, 1'b0, "store_f3_100_illegal");
    access(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, 1'b0, "lw_20_unchanged");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEA5BEEF, 1'b0, 1'b0, "lw_10_unchanged");
  endtask

  task automatic test_wrap_zero_ws();
    access(1, 1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b0, 1'b0, "sw_400_wrap");
    access(1, 1'b0, 3'b010, 32'h000, 32'h0, 32'h12345678, 1'b0, 1'b0, "lw_000_wrap");
    access(1, 1'b0, 3'b000, 32'h401, 32'h0, 32'h00000056, 1'b0, 1'b0, "lb_401");
    access(1, 1'b0, 3'b001, 32'h402, 32'h0, 32'h00001234, 1'b0, 1'b0, "lh_402");
    access(1, 1'b0, 3'b010, 32'h402, 32'h0, 32'h0, 1'b1, 1'b0, "lw_402_mis");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half();
    test_errors();
    test_wrap_zero_ws();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
